// File: rtl/de_scoreboard_mp_pkg.sv
// Shared defaults and helpers for the decode-stage multi-writer register scoreboard.
package de_scoreboard_mp_pkg;

  localparam int unsigned NREGS_D     = 32;
  localparam int unsigned RBITS_D     = 5;
  localparam int unsigned CNT_BITS_D  = 2;
  localparam int unsigned NUM_REL_D   = 2;
  localparam int unsigned BYPASS_WB_D = 1;

  // x0 is hardwired zero and never tracked
  localparam int unsigned REG_ZERO = 0;

  localparam int unsigned REL_BUS_W = 64;
  localparam int unsigned REG_W_MAX = 16;

  // Extract release port k's register number from the flattened release bus
  function automatic logic [REG_W_MAX-1:0] rel_slice(input logic [REL_BUS_W-1:0] bus,
                                                     input int unsigned k,
                                                     input int unsigned rbits);
    logic [REL_BUS_W-1:0] mask;
    mask = (REL_BUS_W'(1) << rbits) - REL_BUS_W'(1);
    return REG_W_MAX'((bus >> (k * rbits)) & mask);
  endfunction

endpackage

// File: rtl/de_scoreboard_mp_if.sv
// Decode-to-scoreboard interface: issue request, release ports and stall/status results.
interface de_scoreboard_mp_if
  import de_scoreboard_mp_pkg::*;
#(
  parameter int unsigned NREGS    = NREGS_D,
  parameter int unsigned RBITS    = RBITS_D,
  parameter int unsigned CNT_BITS = CNT_BITS_D,
  parameter int unsigned NUM_REL  = NUM_REL_D
);

  logic                        iss_valid;
  logic                        use_rs1;
  logic                        use_rs2;
  logic [RBITS-1:0]            rs1;
  logic [RBITS-1:0]            rs2;
  logic                        wr_reg;
  logic [RBITS-1:0]            rd;
  logic                        br_mispred;
  logic [NUM_REL-1:0]          rel_valid;
  logic [NUM_REL*RBITS-1:0]    rel_regno;
  logic                        stall;
  logic                        iss_fire;
  logic [NREGS-1:0]            busy;
  logic [RBITS+CNT_BITS-1:0]   pending;
  logic                        err;

  modport master (
    output iss_valid, use_rs1, use_rs2, rs1, rs2, wr_reg, rd, br_mispred,
           rel_valid, rel_regno,
    input  stall, iss_fire, busy, pending, err
  );

  modport slave (
    input  iss_valid, use_rs1, use_rs2, rs1, rs2, wr_reg, rd, br_mispred,
           rel_valid, rel_regno,
    output stall, iss_fire, busy, pending, err
  );

endinterface

// File: rtl/de_sb_counter.sv
// Per-register in-flight write counter: net alloc/release update with under/overflow flags.
module de_sb_counter #(
  parameter int unsigned CNT_BITS  = 2,
  parameter int unsigned RELW      = 2,
  parameter int unsigned CALC_W    = 7,
  parameter int unsigned BYPASS_WB = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                alloc,
  input  logic [RELW-1:0]     rel_n,
  output logic [CNT_BITS-1:0] cnt,
  output logic                busy,
  output logic                will_clear,
  output logic                underflow,
  output logic                overflow
);

  localparam logic [CALC_W-1:0] MAX_W = CALC_W'((1 << CNT_BITS) - 1);

  logic [CNT_BITS-1:0] cnt_q;
  logic [CNT_BITS-1:0] cnt_d;
  logic [CALC_W-1:0]   add_w;
  logic [CALC_W-1:0]   rel_w;
  logic [CALC_W-1:0]   net_w;

  // Wide net update so cnt + alloc - rel never wraps mid-expression
  always_comb begin
    cnt_d     = cnt_q;
    add_w     = CALC_W'(cnt_q) + CALC_W'(alloc);
    rel_w     = CALC_W'(rel_n);
    net_w     = add_w - rel_w;
    underflow = rel_w > add_w;
    overflow  = !underflow && (net_w > MAX_W);
    if (underflow) begin
      cnt_d = '0;
    end else if (overflow) begin
      cnt_d = '1;
    end else begin
      cnt_d = CNT_BITS'(net_w);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // will_clear: every outstanding write retires this cycle, so readers may bypass
  always_comb begin
    cnt        = cnt_q;
    busy       = (cnt_q != '0);
    will_clear = (BYPASS_WB != 0) && busy && (CALC_W'(cnt_q) <= rel_w);
  end

endmodule

// File: rtl/de_scoreboard_mp.sv
// Decode-stage register scoreboard: counts outstanding writers per register, decides stall/fire.
module de_scoreboard_mp
  import de_scoreboard_mp_pkg::*;
#(
  parameter int unsigned NREGS     = NREGS_D,
  parameter int unsigned RBITS     = RBITS_D,
  parameter int unsigned CNT_BITS  = CNT_BITS_D,
  parameter int unsigned NUM_REL   = NUM_REL_D,
  parameter int unsigned BYPASS_WB = BYPASS_WB_D
) (
  input  logic               clk,
  input  logic               reset_n,
  de_scoreboard_mp_if.slave  sb
);

  localparam int unsigned RELW = $clog2(NUM_REL + 1);
  localparam int unsigned PW   = RBITS + CNT_BITS;
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [RBITS-1:0]    RZ      = RBITS'(REG_ZERO);

  logic [RBITS-1:0]    rel_reg [NUM_REL];
  logic [RELW-1:0]     rel_n   [NREGS];
  logic [CNT_BITS-1:0] cnt     [NREGS];
  logic [NREGS-1:0]    busy;
  logic [NREGS-1:0]    will_clear;
  logic [NREGS-1:0]    underflow;
  logic [NREGS-1:0]    overflow;
  logic [NREGS-1:0]    hazard;
  logic [NREGS-1:0]    full;
  logic                src1_haz;
  logic                src2_haz;
  logic                full_haz;
  logic                stall_c;
  logic                fire_c;
  logic [PW-1:0]       pending;
  logic                err_q;

  always_comb begin
    for (int unsigned k = 0; k < NUM_REL; k++) begin
      rel_reg[k] = RBITS'(rel_slice(REL_BUS_W'(sb.rel_regno), k, RBITS));
    end
  end

  // Per-register release popcount; duplicate ports each count, x0 ignored
  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      rel_n[r] = '0;
      for (int unsigned k = 0; k < NUM_REL; k++) begin
        if ((r != REG_ZERO) && sb.rel_valid[k] && (rel_reg[k] == RBITS'(r))) begin
          rel_n[r] = rel_n[r] + RELW'(1);
        end
      end
    end
  end

  assign cnt[0]        = '0;
  assign busy[0]       = 1'b0;
  assign will_clear[0] = 1'b0;
  assign underflow[0]  = 1'b0;
  assign overflow[0]   = 1'b0;

  for (genvar g = 1; g < NREGS; g++) begin : g_cnt
    de_sb_counter #(
      .CNT_BITS  (CNT_BITS),
      .RELW      (RELW),
      .CALC_W    (PW),
      .BYPASS_WB (BYPASS_WB)
    ) u_cnt (
      .clk        (clk),
      .reset_n    (reset_n),
      .alloc      (fire_c && sb.wr_reg && (sb.rd == RBITS'(g))),
      .rel_n      (rel_n[g]),
      .cnt        (cnt[g]),
      .busy       (busy[g]),
      .will_clear (will_clear[g]),
      .underflow  (underflow[g]),
      .overflow   (overflow[g])
    );
  end

  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      hazard[r] = busy[r] && !will_clear[r];
      full[r]   = (cnt[r] == CNT_MAX) && (rel_n[r] == '0);
    end
  end

  // Stall/fire decision; an instruction's own allocation never hazards its sources
  always_comb begin
    src1_haz = sb.use_rs1 && (sb.rs1 != RZ) && hazard[sb.rs1];
    src2_haz = sb.use_rs2 && (sb.rs2 != RZ) && hazard[sb.rs2];
    full_haz = sb.wr_reg && (sb.rd != RZ) && full[sb.rd];
    stall_c  = (sb.iss_valid && (src1_haz || src2_haz || full_haz)) || sb.br_mispred;
    fire_c   = sb.iss_valid && !stall_c;
  end

  always_comb begin
    pending = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      pending = pending + PW'(cnt[r]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if ((|underflow) || (|overflow)) begin
      err_q <= 1'b1;
    end
  end

  assign sb.stall    = stall_c;
  assign sb.iss_fire = fire_c;
  assign sb.busy     = busy;
  assign sb.pending  = pending;
  assign sb.err      = err_q;

endmodule
